// File: rtl/rr_arbiter8_ctrl_pkg.sv
// Shared definitions for the 8-way round-robin arbiter.
// Holds FSM state encodings, sizing constants and the rotating-priority scan.
package rr_arbiter8_ctrl_pkg;

    localparam int N_REQ    = 8;
    localparam int IDX_W    = 3;
    localparam int MAX_HOLD = 22;
    localparam int HOLD_W   = 6;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_RELEASE = 2'd2
    } arb_state_e;

    // First set request bit scanning ptr, ptr+1, ... modulo N_REQ.
    // Returns ptr when nothing is requesting; callers gate on |req.
    function automatic logic [IDX_W-1:0] rr_pick(
        input logic [N_REQ-1:0] req,
        input logic [IDX_W-1:0] ptr
    );
        logic [IDX_W-1:0] k;
        logic             found;
        rr_pick = ptr;
        found   = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            k = ptr + IDX_W'(i);
            if (!found && req[k]) begin
                rr_pick = k;
                found   = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/rr_arbiter8_ctrl_dec.sv
// 3-to-8 decoder with enable, turns the grant index into the one-hot grant bus.
// Ports: idx_i (index), en_i (enable), dec_o (one-hot, zero when disabled).
module decoder3to8_en
    import rr_arbiter8_ctrl_pkg::*;
(
    input  logic [IDX_W-1:0] idx_i,
    input  logic             en_i,
    output logic [N_REQ-1:0] dec_o
);

    always_comb begin
        dec_o = '0;
        if (en_i) begin
            dec_o = N_REQ'(1) << idx_i;
        end
    end

endmodule

// File: rtl/rr_arbiter8_ctrl.sv
// Round-robin arbiter for 8 requesters sharing one compare/decode datapath.
// Ports: clk, reset_n (async active-low), req[7:0], done[7:0] in;
//   gnt[7:0] one-hot, gnt_idx[2:0], gnt_valid, timeout (1-cycle pulse) out.
// Option RR_ARB_PRIO0_EN: requester 0 wins any arbitration it takes part in.
module rr_arbiter8_ctrl
    import rr_arbiter8_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] done,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid,
    output logic             timeout
);

    arb_state_e        state_q;
    logic [IDX_W-1:0]  ptr_q;
    logic [IDX_W-1:0]  idx_q;
    logic [HOLD_W-1:0] hold_q;
    logic              timeout_q;

    logic [IDX_W-1:0]  ptr_d;
    logic [IDX_W-1:0]  scan_ptr;
    logic [IDX_W-1:0]  idx_d;
    logic              any_req;
    logic              cur_done;
    logic              cur_req;
    logic              expire;
    logic              grant_end;

    assign any_req   = |req;
    assign cur_done  = done[idx_q];
    assign cur_req   = req[idx_q];
    assign expire    = (hold_q == HOLD_W'(MAX_HOLD - 1));
    assign grant_end = cur_done | ~cur_req | expire;

    // Pointer after the current grant; used in RELEASE so the next pick
    // already sees the rotated priority without an extra idle cycle.
    assign ptr_d    = idx_q + IDX_W'(1);
    assign scan_ptr = (state_q == ST_RELEASE) ? ptr_d : ptr_q;

    always_comb begin
        idx_d = rr_pick(req, scan_ptr);
`ifdef RR_ARB_PRIO0_EN
        if (req[0]) begin
            idx_d = '0;
        end
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            idx_q     <= '0;
            hold_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    timeout_q <= 1'b0;
                    if (any_req) begin
                        idx_q   <= idx_d;
                        hold_q  <= '0;
                        state_q <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    if (grant_end) begin
                        // done wins over expiry; a withdraw also suppresses it
                        timeout_q <= expire & ~cur_done & cur_req;
                        hold_q    <= '0;
                        state_q   <= ST_RELEASE;
                    end else begin
                        hold_q <= hold_q + HOLD_W'(1);
                    end
                end
                ST_RELEASE: begin
                    timeout_q <= 1'b0;
                    ptr_q     <= ptr_d;
                    hold_q    <= '0;
                    if (any_req) begin
                        idx_q   <= idx_d;
                        state_q <= ST_GRANT;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    decoder3to8_en u_dec (
        .idx_i (idx_q),
        .en_i  (state_q == ST_GRANT),
        .dec_o (gnt)
    );

    assign gnt_idx   = idx_q;
    assign gnt_valid = (state_q == ST_GRANT);
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_rr_arbiter8_ctrl.sv
// Bench for rr_arbiter8_ctrl: directed scenarios then random traffic,
// every cycle compared against a grant-level reference model.
module tb_rr_arbiter8_ctrl;
    import rr_arbiter8_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] req = 8'h00;
    logic [7:0] done = 8'h00;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;
    logic       timeout;

    int n_checks = 0;
    int n_err = 0;
    int cyc = 0;

    // reference model: who owns the bus, for how long, pending gap
    bit m_busy;
    bit m_gap;
    bit m_to;
    int m_idx;
    int m_ptr;
    int m_len;

    always #5 clk = ~clk;

    rr_arbiter8_ctrl dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req       (req),
        .done      (done),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s cycle=%0d observed=%h expected=%h",
                   tag, cyc, obs, exp);
        end
    endtask

    function automatic int pick(input logic [7:0] r, input int p);
`ifdef RR_ARB_PRIO0_EN
        if (r[0]) return 0;
`endif
        for (int i = 0; i < 8; i++) begin
            if (r[(p + i) % 8]) return (p + i) % 8;
        end
        return -1;
    endfunction

    task automatic m_reset();
        m_busy = 0;
        m_gap = 0;
        m_to = 0;
        m_idx = 0;
        m_ptr = 0;
        m_len = 0;
    endtask

    task automatic m_step(input logic [7:0] r, input logic [7:0] d);
        int p;
        if (m_busy) begin
            m_len++;
            if (d[m_idx] || !r[m_idx] || m_len == MAX_HOLD) begin
                m_to = (m_len == MAX_HOLD) && !d[m_idx] && r[m_idx];
                m_busy = 0;
                m_gap = 1;
            end
        end else begin
            if (m_gap) m_ptr = (m_idx + 1) % 8;
            m_gap = 0;
            m_to = 0;
            p = pick(r, m_ptr);
            if (p >= 0) begin
                m_idx = p;
                m_busy = 1;
                m_len = 0;
            end
        end
    endtask

    task automatic tick();
        logic [7:0] eg;
        @(posedge clk);
        if (!reset_n) m_reset();
        else m_step(req, done);
        #1;
        cyc++;
        eg = 8'h01 << m_idx;
        if (!m_busy) eg = 8'h00;
        chk("gnt", 32'(gnt), 32'(eg));
        chk("gnt_idx", 32'(gnt_idx), 32'(m_idx));
        chk("gnt_valid", 32'(gnt_valid), 32'(m_busy));
        chk("timeout", 32'(timeout), 32'(m_to));
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        req = 8'h00;
        done = 8'h00;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    initial begin
        int w;
        int len;
        m_reset();

        // 1: outputs idle while reset held, even with everyone requesting
        reset_n = 1'b0;
        req = 8'hFF;
        tick();
        tick();
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_idx", 32'(gnt_idx), 32'h0);
        reset_n = 1'b1;

        // 2: single request, one-cycle latency, done releases
        req = 8'h01;
        tick();
        chk("t2_gnt", 32'(gnt), 32'h01);
        done = 8'h01;
        tick();
        chk("t2_rel", 32'(gnt), 32'h00);
        req = 8'h00;
        done = 8'h00;
        tick();
        chk("t2_idle", 32'(gnt_valid), 32'h0);

        // 3: all requesting, fair rotation with a single gap cycle
        do_reset();
        req = 8'hFF;
        for (int g = 0; g < 9; g++) begin
            w = 0;
            while (!gnt_valid && w < 4) begin
                tick();
                w++;
            end
            chk("t3_gap", 32'(w), 32'd1);
            chk("t3_order", 32'(gnt_idx), 32'(g % 8));
            tick();
            done = 8'h01 << gnt_idx;
            tick();
            chk("t3_rel", 32'(gnt), 32'h00);
            done = 8'h00;
        end

        // 4: grant held to expiry, timeout pulse, re-grant
        do_reset();
        req = 8'h08;
        tick();
        len = 0;
        while (gnt_valid && len < 40) begin
            len++;
            tick();
        end
        chk("t4_len", 32'(len), 32'(MAX_HOLD));
        chk("t4_to", 32'(timeout), 32'h1);
        chk("t4_gap", 32'(gnt), 32'h00);
        tick();
        chk("t4_regrant", 32'(gnt), 32'h08);
        chk("t4_to_off", 32'(timeout), 32'h0);

        // 5: asynchronous reset in the middle of a grant
        do_reset();
        req = 8'h30;
        tick();
        chk("t5_gnt", 32'(gnt), 32'h10);
        tick();
        #2;
        reset_n = 1'b0;
        #1;
        m_reset();
        chk("t5_async", 32'(gnt), 32'h00);
        chk("t5_async_to", 32'(timeout), 32'h0);
        tick();
        reset_n = 1'b1;
        tick();
        chk("t5_after", 32'(gnt_idx), 32'h4);

        // 6: ptr moved to 5, then requesters 0 and 5 compete
        do_reset();
        req = 8'h10;
        tick();
        done = 8'h10;
        tick();
        done = 8'h00;
        req = 8'h00;
        tick();
        req = 8'h21;
        tick();
`ifdef RR_ARB_PRIO0_EN
        chk("t6_prio", 32'(gnt), 32'h01);
`else
        chk("t6_rr", 32'(gnt), 32'h20);
`endif

        // random traffic: sticky requests, sparse done strobes
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 5) == 0) req = 8'($urandom);
            if ($urandom_range(0, 7) == 0) done = 8'($urandom);
            else done = 8'h00;
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_err);
        $finish;
    end

endmodule
